// File: rtl/dram_burst_bridge_pkg.sv
// Shared types for the client-to-AXI4 burst bridge: AXI response codes,
// bridge FSM states and the fixed AXI LEN width.
package bridge_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/dram_burst_bridge_if.sv
// Client command/data signals plus the five AXI4 channels of the bridge.
// Every VALID/READY pair transfers on a rising edge where both are 1; VALID, once raised, holds its payload until then.
interface dram_burst_bridge_if #(
    parameter int DATA_W     = 64,
    parameter int CADDR_W    = 8,
    parameter int AXI_ADDR_W = 17,
    parameter int LEN_W      = 4
);
    logic                  C_in_valid;
    logic                  C_r_wb;
    logic [CADDR_W-1:0]    C_addr;
    logic [LEN_W-1:0]      C_len;
    logic                  C_w_valid;
    logic                  C_w_ready;
    logic [DATA_W-1:0]     C_data_w;
    logic                  C_out_valid;
    logic                  C_out_ready;
    logic [DATA_W-1:0]     C_data_r;
    logic                  C_done;
    logic                  C_err;
    logic                  C_idle;

    logic                  AR_VALID;
    logic                  AR_READY;
    logic [AXI_ADDR_W-1:0] AR_ADDR;
    logic [7:0]            AR_LEN;
    logic                  R_VALID;
    logic                  R_LAST;
    logic                  R_READY;
    logic [DATA_W-1:0]     R_DATA;
    logic [1:0]            R_RESP;
    logic                  AW_VALID;
    logic                  AW_READY;
    logic [AXI_ADDR_W-1:0] AW_ADDR;
    logic [7:0]            AW_LEN;
    logic                  W_VALID;
    logic                  W_LAST;
    logic                  W_READY;
    logic [DATA_W-1:0]     W_DATA;
    logic                  B_VALID;
    logic                  B_READY;
    logic [1:0]            B_RESP;

    modport master (
        input  C_in_valid, C_r_wb, C_addr, C_len, C_w_valid, C_data_w, C_out_ready,
        input  AR_READY, R_VALID, R_LAST, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP,
        output C_w_ready, C_out_valid, C_data_r, C_done, C_err, C_idle,
        output AR_VALID, AR_ADDR, AR_LEN, R_READY, AW_VALID, AW_ADDR, AW_LEN,
        output W_VALID, W_LAST, W_DATA, B_READY
    );

    modport slave (
        output C_in_valid, C_r_wb, C_addr, C_len, C_w_valid, C_data_w, C_out_ready,
        output AR_READY, R_VALID, R_LAST, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP,
        input  C_w_ready, C_out_valid, C_data_r, C_done, C_err, C_idle,
        input  AR_VALID, AR_ADDR, AR_LEN, R_READY, AW_VALID, AW_ADDR, AW_LEN,
        input  W_VALID, W_LAST, W_DATA, B_READY
    );

endinterface

// File: rtl/dram_burst_bridge_fifo.sv
// Show-ahead synchronous FIFO; push while full and pop while empty are ignored.
module bridge_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_burst_bridge.sv
// Turns one client command of 1..MAX_BEATS beats into one AXI4 INCR burst; write
// beats are queued in a FIFO so W can run ahead of AW.
module dram_burst_bridge
    import bridge_pkg::*;
#(
    parameter int                  DATA_W     = 64,
    parameter int                  CADDR_W    = 8,
    parameter int                  AXI_ADDR_W = 17,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 17'h10000,
    parameter int                  MAX_BEATS  = 16,
    localparam int                 LEN_W      = $clog2(MAX_BEATS),
    localparam int                 FCNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    dram_burst_bridge_if.master bus,
    output bridge_state_t       o_state,
    output logic [FCNT_W-1:0]   o_fifo_count
);
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    bridge_state_t         r_state;
    bridge_state_t         w_next;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_beat;
    logic [AXI_ADDR_W-1:0] r_axi_addr;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_err;

    logic                  w_ar_valid;
    logic                  w_r_ready;
    logic                  w_out_valid;
    logic [DATA_W-1:0]     w_data_r;
    logic                  w_aw_valid;
    logic                  w_w_valid;
    logic                  w_w_last;
    logic                  w_b_ready;
    logic                  w_done;
    logic                  w_idle;
    logic                  w_r_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;

    logic [DATA_W-1:0]     w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    bridge_fifo #(.WIDTH(DATA_W), .DEPTH(MAX_BEATS)) u_wfifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (bus.C_w_valid),
        .i_data  (bus.C_data_w),
        .i_pop   (w_w_hs),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_fifo_count)
    );

    always_comb begin
        w_next      = r_state;
        w_ar_valid  = 1'b0;
        w_r_ready   = 1'b0;
        w_out_valid = 1'b0;
        w_data_r    = '0;
        w_aw_valid  = 1'b0;
        w_w_valid   = 1'b0;
        w_w_last    = 1'b0;
        w_b_ready   = 1'b0;
        w_done      = 1'b0;
        w_idle      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (bus.C_in_valid) w_next = bus.C_r_wb ? ST_RD_ADDR : ST_WR;
            end
            ST_RD_ADDR: begin
                w_ar_valid = 1'b1;
                if (bus.AR_READY) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // Read beats pass straight through; the client's ready is the AXI ready.
                w_r_ready   = bus.C_out_ready;
                w_out_valid = bus.R_VALID;
                w_data_r    = bus.R_VALID ? bus.R_DATA : '0;
                if (bus.R_VALID && bus.C_out_ready && (bus.R_LAST || r_beat == r_len))
                    w_next = ST_RESP;
            end
            ST_WR: begin
                w_aw_valid = !r_aw_done;
                w_w_valid  = !w_fifo_empty && !r_w_done;
                w_w_last   = w_w_valid && (r_beat == r_len);
                w_b_ready  = r_aw_done && r_w_done;
                if (bus.B_VALID && w_b_ready) w_next = ST_RESP;
            end
            ST_RESP: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_r_hs  = w_out_valid && bus.C_out_ready;
    assign w_aw_hs = w_aw_valid && bus.AW_READY;
    assign w_w_hs  = w_w_valid && bus.W_READY;
    assign w_b_hs  = w_b_ready && bus.B_VALID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_beat     <= '0;
            r_axi_addr <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.C_in_valid) begin
                        r_len      <= bus.C_len;
                        r_beat     <= '0;
                        r_axi_addr <= BASE_ADDR | (AXI_ADDR_W'(bus.C_addr) << BYTE_SH);
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (w_r_hs) begin
                        r_beat <= r_beat + 1'b1;
                        if (bus.R_RESP != RESP_OKAY) r_err <= 1'b1;
                        // A slave closing the burst short is reported as an error.
                        if (bus.R_LAST && r_beat != r_len) r_err <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == r_len) r_w_done <= 1'b1;
                    end
                    if (w_b_hs && bus.B_RESP != RESP_OKAY) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_state         = r_state;
    assign bus.C_w_ready   = !w_fifo_full;
    assign bus.C_out_valid = w_out_valid;
    assign bus.C_data_r    = w_data_r;
    assign bus.C_done      = w_done;
    assign bus.C_err       = w_done && r_err;
    assign bus.C_idle      = w_idle;
    assign bus.AR_VALID    = w_ar_valid;
    assign bus.AR_ADDR     = r_axi_addr;
    assign bus.AR_LEN      = AXI_LEN_W'(r_len);
    assign bus.R_READY     = w_r_ready;
    assign bus.AW_VALID    = w_aw_valid;
    assign bus.AW_ADDR     = r_axi_addr;
    assign bus.AW_LEN      = AXI_LEN_W'(r_len);
    assign bus.W_VALID     = w_w_valid;
    assign bus.W_LAST      = w_w_last;
    assign bus.W_DATA      = w_fifo_data;
    assign bus.B_READY     = w_b_ready;

endmodule

// File: tb/tb_dram_burst_bridge.sv
// Bench for dram_burst_bridge: table-driven read/write bursts against a small
// DRAM slave model, plus hand-written FIFO-full and mid-burst reset sequences.
module tb_dram_burst_bridge;
    import bridge_pkg::*;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int AW   = 17;
    localparam int LW   = 4;
    localparam int MAXB = 16;

    typedef struct {
        logic [CW-1:0] addr;
        logic [LW-1:0] len;
        int            last_at;
        int            err_beat;
        int            mode;
        logic [DW-1:0] d0;
        logic          exp_err;
    } rd_vec_t;

    typedef struct {
        logic [CW-1:0] addr;
        logic [LW-1:0] len;
        int            npre;
        int            npost;
        int            aw_delay;
        logic [1:0]    bresp;
        logic          exp_err;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bridge_state_t dbg_state;
    logic [4:0]    dbg_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] rdat [MAXB];
    logic aw_hs_seen;
    logic w_early;
    rd_vec_t rd_tab [6];
    wr_vec_t wr_tab [6];

    always #5 clk = ~clk;

    dram_burst_bridge_if #(.DATA_W(DW), .CADDR_W(CW), .AXI_ADDR_W(AW), .LEN_W(LW)) bus ();

    dram_burst_bridge #(
        .DATA_W(DW), .CADDR_W(CW), .AXI_ADDR_W(AW), .BASE_ADDR(17'h10000), .MAX_BEATS(MAXB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .o_state      (dbg_state),
        .o_fifo_count (dbg_cnt)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] exp_addr(input logic [CW-1:0] a);
        return 17'h10000 | (AW'(a) << 3);
    endfunction

    task automatic push_beat(input logic [DW-1:0] d);
        bus.C_w_valid = 1'b1;
        bus.C_data_w  = d;
        wr_q.push_back(d);
        @(negedge clk);
        chk("w_ready_push", bus.C_w_ready, 1);
        tick();
        bus.C_w_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic rwb, input logic [CW-1:0] a, input logic [LW-1:0] l);
        chk("idle_before_cmd", bus.C_idle, 1);
        bus.C_in_valid = 1'b1;
        bus.C_r_wb     = rwb;
        bus.C_addr     = a;
        bus.C_len      = l;
        tick();
        bus.C_in_valid = 1'b0;
        chk("idle_after_cmd", bus.C_idle, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ar_valid"}, bus.AR_VALID, 0);
        chk({tag, "_aw_valid"}, bus.AW_VALID, 0);
        chk({tag, "_w_valid"}, bus.W_VALID, 0);
        chk({tag, "_r_ready"}, bus.R_READY, 0);
        chk({tag, "_b_ready"}, bus.B_READY, 0);
        chk({tag, "_out_valid"}, bus.C_out_valid, 0);
        chk({tag, "_data_r"}, bus.C_data_r, 0);
        chk({tag, "_done"}, bus.C_done, 0);
        chk({tag, "_err"}, bus.C_err, 0);
        chk({tag, "_idle"}, bus.C_idle, 1);
        chk({tag, "_w_ready"}, bus.C_w_ready, 1);
        chk({tag, "_fifo_cnt"}, dbg_cnt, 0);
        chk({tag, "_aw_addr"}, bus.AW_ADDR, 0);
        chk({tag, "_ar_len"}, bus.AR_LEN, 0);
    endtask

    task automatic do_read(input rd_vec_t v);
        int n;
        n = (v.last_at < int'(v.len)) ? v.last_at + 1 : int'(v.len) + 1;
        for (int i = 0; i < n; i++) begin
            rdat[i] = (i == 0 && v.d0 != 0) ? v.d0 : {$urandom, $urandom};
            rd_q.push_back(rdat[i]);
        end
        issue_cmd(1'b1, v.addr, v.len);
        chk("ar_valid", bus.AR_VALID, 1);
        chk("ar_addr", bus.AR_ADDR, exp_addr(v.addr));
        chk("ar_len", bus.AR_LEN, {4'b0, v.len});
        // A command offered while busy must not disturb the latched one.
        bus.C_in_valid = 1'b1;
        bus.C_r_wb     = 1'b0;
        bus.C_addr     = ~v.addr;
        tick();
        bus.C_in_valid = 1'b0;
        bus.AR_READY   = 1'b1;
        @(negedge clk);
        chk("ar_valid_held", bus.AR_VALID, 1);
        chk("ar_addr_held", bus.AR_ADDR, exp_addr(v.addr));
        tick();
        bus.AR_READY = 1'b0;
        fork
            begin : r_drv
                int cyc;
                logic hs;
                for (int i = 0; i < n; i++) begin
                    bus.R_VALID = 1'b1;
                    bus.R_DATA  = rdat[i];
                    bus.R_LAST  = (i == v.last_at);
                    bus.R_RESP  = (i == v.err_beat) ? 2'b10 : 2'b00;
                    cyc = 0;
                    hs  = 1'b0;
                    while (!hs && cyc < 100) begin
                        @(negedge clk);
                        hs = bus.R_VALID && bus.R_READY;
                        tick();
                        cyc++;
                    end
                    if (!hs) fail_now("r_beat_handshake");
                end
                bus.R_VALID = 1'b0;
                bus.R_LAST  = 1'b0;
                bus.R_RESP  = 2'b00;
            end
            begin : client
                int cyc;
                logic done;
                cyc  = 0;
                done = 1'b0;
                while (!done && cyc < 400) begin
                    case (v.mode)
                        0:       bus.C_out_ready = 1'b1;
                        1:       bus.C_out_ready = cyc[0];
                        default: bus.C_out_ready = 1'($urandom_range(0, 1));
                    endcase
                    @(negedge clk);
                    if (dbg_state == ST_RD_DATA) chk("r_ready_mirror", bus.R_READY, bus.C_out_ready);
                    if (!bus.C_out_valid) chk("data_r_idle_zero", bus.C_data_r, 0);
                    if (bus.C_out_valid && bus.C_out_ready) begin
                        if (rd_q.size() == 0) fail_now("rd_extra_beat");
                        else chk("rd_data", bus.C_data_r, rd_q.pop_front());
                    end
                    if (bus.C_done) begin
                        chk("rd_err", bus.C_err, v.exp_err);
                        done = 1'b1;
                    end
                    tick();
                    cyc++;
                end
                if (!done) fail_now("rd_done");
                bus.C_out_ready = 1'b0;
            end
        join
        chk("rd_q_empty", rd_q.size(), 0);
        chk("idle_after_rd", bus.C_idle, 1);
    endtask

    task automatic do_write(input wr_vec_t v);
        for (int i = 0; i < v.npre; i++) push_beat({$urandom, $urandom});
        issue_cmd(1'b0, v.addr, v.len);
        chk("aw_valid", bus.AW_VALID, 1);
        chk("aw_addr", bus.AW_ADDR, exp_addr(v.addr));
        chk("aw_len", bus.AW_LEN, {4'b0, v.len});
        aw_hs_seen = 1'b0;
        w_early    = 1'b0;
        fork
            begin : aw_drv
                int cyc;
                logic hs;
                repeat (v.aw_delay) tick();
                bus.AW_READY = 1'b1;
                cyc = 0;
                hs  = 1'b0;
                while (!hs && cyc < 50) begin
                    @(negedge clk);
                    hs = bus.AW_VALID && bus.AW_READY;
                    tick();
                    cyc++;
                end
                bus.AW_READY = 1'b0;
                if (hs) aw_hs_seen = 1'b1;
                else fail_now("aw_handshake");
            end
            begin : post_push
                for (int i = 0; i < v.npost; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_beat({$urandom, $urandom});
                end
            end
            begin : wb_drv
                int idx;
                int cyc;
                logic hs;
                logic done;
                bus.W_READY = 1'b1;
                idx = 0;
                cyc = 0;
                while (idx <= int'(v.len) && cyc < 300) begin
                    @(negedge clk);
                    if (bus.W_VALID && bus.W_READY) begin
                        if (wr_q.size() == 0) fail_now("w_extra_beat");
                        else chk("w_data", bus.W_DATA, wr_q.pop_front());
                        chk("w_last", bus.W_LAST, idx == int'(v.len));
                        if (!aw_hs_seen) w_early = 1'b1;
                        idx++;
                    end
                    tick();
                    cyc++;
                end
                if (idx <= int'(v.len)) fail_now("w_beats");
                @(negedge clk);
                chk("w_stops_after_last", bus.W_VALID, 0);
                tick();
                bus.W_READY = 1'b0;
                bus.B_VALID = 1'b1;
                bus.B_RESP  = v.bresp;
                cyc = 0;
                hs  = 1'b0;
                while (!hs && cyc < 100) begin
                    @(negedge clk);
                    hs = bus.B_VALID && bus.B_READY;
                    tick();
                    cyc++;
                end
                bus.B_VALID = 1'b0;
                bus.B_RESP  = 2'b00;
                if (!hs) fail_now("b_handshake");
                cyc  = 0;
                done = 1'b0;
                while (!done && cyc < 20) begin
                    @(negedge clk);
                    if (bus.C_done) begin
                        chk("wr_err", bus.C_err, v.exp_err);
                        done = 1'b1;
                    end
                    tick();
                    cyc++;
                end
                if (!done) fail_now("wr_done");
            end
        join
        if (v.aw_delay > 1 && v.npre > 0) chk("w_before_aw", w_early, 1);
        chk("idle_after_wr", bus.C_idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.C_in_valid  = 1'b0;
        bus.C_r_wb      = 1'b0;
        bus.C_addr      = '0;
        bus.C_len       = '0;
        bus.C_w_valid   = 1'b0;
        bus.C_data_w    = '0;
        bus.C_out_ready = 1'b0;
        bus.AR_READY    = 1'b0;
        bus.R_VALID     = 1'b0;
        bus.R_LAST      = 1'b0;
        bus.R_DATA      = '0;
        bus.R_RESP      = 2'b00;
        bus.AW_READY    = 1'b0;
        bus.W_READY     = 1'b0;
        bus.B_VALID     = 1'b0;
        bus.B_RESP      = 2'b00;

        rd_tab[0] = '{8'h05, 4'd0,  0,  -1, 0, 64'hDEAD, 1'b0};
        rd_tab[1] = '{8'h10, 4'd3,  3,  -1, 1, 64'h0,    1'b0};
        rd_tab[2] = '{8'hFF, 4'd15, 15, -1, 2, 64'h0,    1'b0};
        rd_tab[3] = '{8'h20, 4'd3,  2,  -1, 0, 64'h0,    1'b1};
        rd_tab[4] = '{8'h33, 4'd2,  2,  1,  0, 64'h0,    1'b1};
        rd_tab[5] = '{8'h00, 4'd1,  1,  -1, 1, 64'h0,    1'b0};

        wr_tab[0] = '{8'h40, 4'd7, 8, 0, 4, 2'b00, 1'b0};
        wr_tab[1] = '{8'h01, 4'd0, 0, 1, 0, 2'b10, 1'b1};
        wr_tab[2] = '{8'h02, 4'd3, 2, 2, 0, 2'b00, 1'b0};
        wr_tab[3] = '{8'h80, 4'd1, 4, 0, 1, 2'b11, 1'b1};
        wr_tab[4] = '{8'h81, 4'd1, 0, 0, 2, 2'b01, 1'b1};
        wr_tab[5] = '{8'h82, 4'd2, 3, 0, 0, 2'b00, 1'b0};

        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) do_read(rd_tab[i]);
        for (int i = 0; i < 6; i++) do_write(wr_tab[i]);

        // Fill the FIFO, then try one beat too many.
        chk("fifo_empty_before_fill", wr_q.size(), 0);
        for (int i = 0; i < MAXB; i++) push_beat({$urandom, $urandom});
        @(negedge clk);
        chk("full_w_ready", bus.C_w_ready, 0);
        chk("full_count", dbg_cnt, MAXB);
        tick();
        bus.C_w_valid = 1'b1;
        bus.C_data_w  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bus.C_w_valid = 1'b0;
        chk("full_count_after_17th", dbg_cnt, MAXB);
        do_write('{8'h90, 4'd15, 0, 0, 0, 2'b00, 1'b0});
        do_write('{8'h91, 4'd0, 1, 0, 0, 2'b00, 1'b0});

        // Reset in the middle of a write burst after three W beats.
        begin
            int idx;
            int cyc;
            for (int i = 0; i < 8; i++) push_beat({$urandom, $urandom});
            issue_cmd(1'b0, 8'h55, 4'd7);
            bus.AW_READY = 1'b0;
            bus.W_READY  = 1'b1;
            idx = 0;
            cyc = 0;
            while (idx < 3 && cyc < 50) begin
                @(negedge clk);
                if (bus.W_VALID && bus.W_READY) begin
                    chk("rst_w_data", bus.W_DATA, wr_q.pop_front());
                    idx++;
                end
                tick();
                cyc++;
            end
            if (idx < 3) fail_now("rst_w_beats");
            bus.W_READY = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midburst_reset");
            wr_q.delete();
            tick();
            tick();
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("no_done_after_reset", bus.C_done, 0);
                chk("idle_after_reset", bus.C_idle, 1);
                tick();
            end
        end

        do_write('{8'h12, 4'd0, 1, 0, 0, 2'b00, 1'b0});
        chk("wr_q_empty_end", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
